// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipelined CPU.
// Holds the data memory (single-port synchronous block RAM, read-before-write)
// and the memory-mapped io_out register. It also carries the pipeline
// register toward write_back, so ALU result, load data and control bits
// arrive aligned in the same cycle.
module mem_stage #(
    parameter int          DM_ADDR_W = 8,
    parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        x_valid,
    input  logic [15:0] x_alu_result,
    input  logic [15:0] x_store_data,
    input  logic [2:0]  x_reg_waddr,
    input  logic        x_dm_wea,
    input  logic        x_dm_rea,
    input  logic        x_reg_data_loc,
    input  logic        x_reg_load,
    output logic        m_valid,
    output logic [15:0] m_alu_result,
    output logic [15:0] m_dm_dout,
    output logic [2:0]  m_reg_waddr,
    output logic        m_reg_data_loc,
    output logic        m_reg_load,
    output logic [15:0] io_out
);

    localparam int DM_DEPTH = 1 << DM_ADDR_W;

    // Which source the registered load data comes from.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } dout_sel_t;

    logic [15:0] r_mem [DM_DEPTH];
    logic [15:0] r_ram_q;
    logic [15:0] r_io_q;
    logic [15:0] r_io_out;
    logic        r_valid;
    logic [15:0] r_alu_result;
    logic [2:0]  r_reg_waddr;
    logic        r_reg_data_loc;
    logic        r_reg_load;
    dout_sel_t   r_dout_sel;

    logic                 w_io_hit;
    logic [DM_ADDR_W-1:0] w_idx;
    logic                 w_act;
    logic                 w_store;
    logic                 w_load;
    logic                 w_ram_en;
    logic                 w_ram_we;

    // Address decode: io register needs an exact match; everything else
    // aliases onto the RAM through the low index bits.
    assign w_io_hit = (x_alu_result == IO_ADDR);
    assign w_idx    = x_alu_result[DM_ADDR_W-1:0];
    assign w_act    = x_valid & ~stall & ~flush & ~rst;
    assign w_store  = w_act & x_dm_wea;
    assign w_load   = w_act & x_dm_rea;
    // The RAM port is clocked whenever the stage advances so its output
    // register holds through a stall; a write needs a live, non-io store.
    assign w_ram_en = ~stall;
    assign w_ram_we = w_store & ~w_io_hit;

    // Single-port block RAM, read-first: a simultaneous load+store sees old data.
    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            if (w_ram_we) begin
                r_mem[w_idx] <= x_store_data;
            end
            r_ram_q <= r_mem[w_idx];
        end
    end

    // Memory-mapped output register; written only by a live store to IO_ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_out <= 16'h0000;
        end else if (w_store && w_io_hit) begin
            r_io_out <= x_store_data;
        end
    end

    // Pipeline register toward write_back: rst > flush > stall > normal.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid        <= 1'b0;
            r_alu_result   <= 16'h0000;
            r_reg_waddr    <= 3'd0;
            r_reg_data_loc <= 1'b0;
            r_reg_load     <= 1'b0;
            r_dout_sel     <= SEL_ZERO;
            r_io_q         <= 16'h0000;
        end else if (!stall) begin
            r_valid        <= x_valid;
            r_alu_result   <= x_alu_result;
            r_reg_waddr    <= x_reg_waddr;
            r_reg_data_loc <= x_reg_data_loc & x_valid;
            r_reg_load     <= x_reg_load & x_valid;
            if (w_load) begin
                r_dout_sel <= w_io_hit ? SEL_IO : SEL_RAM;
            end else begin
                r_dout_sel <= SEL_ZERO;
            end
            // Capture the pre-store io value so a load+store of IO_ADDR reads old data.
            r_io_q         <= r_io_out;
        end
    end

    // Select load data from the RAM output register or the captured io value.
    always_comb begin
        m_dm_dout = 16'h0000;
        case (r_dout_sel)
            SEL_RAM: m_dm_dout = r_ram_q;
            SEL_IO:  m_dm_dout = r_io_q;
            default: m_dm_dout = 16'h0000;
        endcase
    end

    assign m_valid        = r_valid;
    assign m_alu_result   = r_alu_result;
    assign m_reg_waddr    = r_reg_waddr;
    assign m_reg_data_loc = r_reg_data_loc;
    assign m_reg_load     = r_reg_load;
    assign io_out         = r_io_out;

endmodule
